ahb_slv_mem: RTL and testbench
==============================

AHB_SLV_MEM -- requirements
Module: ahb_slv_mem

Interface
REQ-001 Parameter MEM_DEPTH, default 64, number of 32-bit words; legal byte range 0 to MEM_DEPTH*4-1.
REQ-002 Parameter WAIT_STATES, default 0, number of hready_resp-low cycles inserted per OKAY data phase; legal range 0-3.
REQ-003 Port hclk  input  1  sole clock; all state changes on the rising edge.
REQ-004 Port hresetn  input  1  asynchronous active-low reset.
REQ-005 Port hsel  input  1  slave select, address phase.
REQ-006 Port hwrite  input  1  1 = write, 0 = read, address phase.
REQ-007 Port hready  input  1  bus ready; an address phase is sampled only when hready=1.
REQ-008 Port hsize  input  3  transfer size: 0 = byte, 1 = half, 2 = word.
REQ-009 Port hburst  input  3  burst type; accepted and otherwise ignored.
REQ-010 Port htrans  input  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-011 Port hwdata  input  32  write data, data phase.
REQ-012 Port haddr  input  32  byte address, address phase.
REQ-013 Port hready_resp  output  1  slave ready; 0 extends the current data phase.
REQ-014 Port hresp  output  2  00 = OKAY, 01 = ERROR.
REQ-015 Port hrdata  output  32  read data, data phase.

Function
REQ-016 A transfer shall be accepted on a rising edge where hsel=1, hready=1 and htrans is NONSEQ or SEQ; haddr, hwrite and hsize shall be latched at that edge.
REQ-017 IDLE or BUSY with hsel=1, and any cycle with hsel=0, shall produce a zero-wait OKAY data phase with no memory access.
REQ-018 An accepted transfer shall be an error if any of the following holds: hsize>2; haddr not aligned to the size (half: haddr[0]=1; word: haddr[1:0]!=0); or haddr >= MEM_DEPTH*4.
REQ-019 FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
REQ-020 FSM transitions on an accepted transfer: error → ERR1; WAIT_STATES>0 → WAIT; otherwise → DATA.
REQ-021 WAIT shall count WAIT_STATES cycles with hready_resp=0 and hresp=00, then go to DATA.
REQ-022 DATA shall drive hready_resp=1 and hresp=00, and shall complete the transfer at the closing edge.
REQ-023 ERR1 shall drive hready_resp=0 and hresp=01; ERR2 shall drive hready_resp=1 and hresp=01.
REQ-024 An error transfer shall never modify memory.
REQ-025 A write shall update memory only at the edge ending DATA, using hwdata on the selected byte lanes: little-endian; byte lane = haddr[1:0]; half lanes = haddr[1]; word = all lanes. Unselected bytes are unchanged.
REQ-026 A read shall drive hrdata with the full 32-bit word at the latched address while in DATA; hrdata=0 in all other states.
REQ-027 A new address phase shall be accepted in the last data-phase cycle (DATA or ERR2), so back-to-back transfers complete with no idle cycle.
REQ-028 The FSM shall return to IDLE when the last data-phase cycle ends with no new accepted transfer.
REQ-029 A read whose address phase overlaps the DATA cycle of a write to the same word shall return the newly written data.
REQ-030 SEQ shall be treated identically to NONSEQ; burst address wrap is the master's responsibility.

Reset
REQ-031 While hresetn=0: FSM=IDLE, wait counter=0, hready_resp=1, hresp=00, hrdata=0, all memory words=0.
REQ-032 Reset asserted mid-transfer shall abort the transfer with no memory write; the first accepted transfer after deassertion shall behave normally.

Verification
REQ-033 WAIT_STATES=0: word write 0xDEADBEEF @0x10, then word read @0x10 → hrdata=0xDEADBEEF in the read data phase; hready_resp=1 and hresp=00 throughout.
REQ-034 Memory holds 0x11223344 @0x20; byte write hwdata=0x0000AA00 @0x21, then word read @0x20 → 0x1122AA44.
REQ-035 Word read @0x102 and word read @0x100 (MEM_DEPTH=64) → each gives two cycles of hresp=01 (hready_resp 0 then 1); memory unchanged.
REQ-036 WAIT_STATES=2: read @0x0 → exactly 2 cycles of hready_resp=0, then DATA with hrdata=0x00000000.
REQ-037 Back-to-back write 0x5A5A5A5A @0x4 with read @0x4 in the write's data phase → read returns 0x5A5A5A5A with no bubble cycle.
REQ-038 hresetn pulsed low during the WAIT of a write → memory word remains 0; outputs return to reset values immediately.

Source files
------------

// File: rtl/ahb_slv_mem.sv
// AHB-Lite slave backed by a resettable word memory, with optional wait
// states, byte/half/word writes and a two-cycle ERROR response.
module ahb_slv_mem #(
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic        hwrite,
  input  logic        hready,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [1:0]  htrans,
  input  logic [31:0] hwdata,
  input  logic [31:0] haddr,
  output logic        hready_resp,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata
);

  localparam int          IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int          AW        = IDX_W + 2;
  localparam logic [31:0] MEM_BYTES = 32'(MEM_DEPTH * 4);
  localparam logic [1:0]  WAIT_LAST = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

  typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;

  state_t            state_reg, state_next;
  logic [1:0]        wait_cnt_reg, wait_cnt_next;
  logic [AW-1:0]     addr_reg;
  logic              write_reg;
  logic [1:0]        size_reg;
  logic              accept;
  logic              req_err;
  logic              mem_we;
  logic [3:0]        byte_en;
  logic [IDX_W-1:0]  mem_idx;
  logic [MEM_DEPTH*32-1:0] mem_flat;
  logic              unused_inputs;

  // Burst type is irrelevant here, and SEQ/NONSEQ are handled alike.
  assign unused_inputs = ^{hburst, htrans[0]};

  // New address phases are only taken when no data phase is still pending.
  assign accept = hsel && hready && htrans[1] &&
                  (state_reg == IDLE || state_reg == DATA || state_reg == ERR2);

  assign req_err = (hsize > 3'd2) ||
                   (hsize == 3'd1 && haddr[0]) ||
                   (hsize == 3'd2 && (haddr[1:0] != 2'b00)) ||
                   (haddr >= MEM_BYTES);

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      IDLE, DATA, ERR2: begin
        wait_cnt_next = 2'd0;
        if (accept) begin
          if (req_err)              state_next = ERR1;
          else if (WAIT_STATES > 0) state_next = WAIT;
          else                      state_next = DATA;
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (wait_cnt_reg == WAIT_LAST) begin
          state_next    = DATA;
          wait_cnt_next = 2'd0;
        end else begin
          wait_cnt_next = wait_cnt_reg + 2'd1;
        end
      end
      ERR1:    state_next = ERR2;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= 2'd0;
      addr_reg     <= '0;
      write_reg    <= 1'b0;
      size_reg     <= 2'd0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (accept) begin
        addr_reg  <= haddr[AW-1:0];
        write_reg <= hwrite;
        size_reg  <= hsize[1:0];
      end
    end
  end

  assign mem_we  = (state_reg == DATA) && write_reg;
  assign mem_idx = addr_reg[AW-1:2];

  always_comb begin
    byte_en = 4'b1111;
    case (size_reg)
      2'd0:    byte_en = 4'b0001 << addr_reg[1:0];
      2'd1:    byte_en = addr_reg[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  end

  // Storage is flops rather than RAM because every word must clear on reset.
  generate
    for (genvar gi = 0; gi < MEM_DEPTH; gi++) begin : g_word
      logic [31:0] word_reg;
      always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
          word_reg <= 32'd0;
        end else if (mem_we && mem_idx == IDX_W'(gi)) begin
          for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) word_reg[8*b +: 8] <= hwdata[8*b +: 8];
          end
        end
      end
      assign mem_flat[32*gi +: 32] = word_reg;
    end
  endgenerate

  // Reading straight from storage makes a write in DATA visible to a read
  // whose data phase starts on the very next cycle.
  always_comb begin
    hready_resp = 1'b1;
    hresp       = 2'b00;
    hrdata      = 32'd0;
    case (state_reg)
      WAIT: hready_resp = 1'b0;
      DATA: if (!write_reg) hrdata = mem_flat[32*int'(mem_idx) +: 32];
      ERR1: begin
        hready_resp = 1'b0;
        hresp       = 2'b01;
      end
      ERR2: hresp = 2'b01;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb_slv_mem.sv
// Directed bench for ahb_slv_mem: one zero-wait instance and one two-wait
// instance share the bus; hsel picks which one a step talks to.
module tb_ahb_slv_mem;

  logic        hclk;
  logic        hresetn;
  logic        hsel0, hsel2;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic [31:0] haddr;
  logic        rdy0, rdy2;
  logic [1:0]  resp0, resp2;
  logic [31:0] rdata0, rdata2;

  int total = 0;
  int bad   = 0;

  ahb_slv_mem #(.MEM_DEPTH(64), .WAIT_STATES(0)) dut0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .hwrite(hwrite), .hready(rdy0),
    .hsize(hsize), .hburst(hburst), .htrans(htrans), .hwdata(hwdata), .haddr(haddr),
    .hready_resp(rdy0), .hresp(resp0), .hrdata(rdata0)
  );

  ahb_slv_mem #(.MEM_DEPTH(64), .WAIT_STATES(2)) dut2 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel2), .hwrite(hwrite), .hready(rdy2),
    .hsize(hsize), .hburst(hburst), .htrans(htrans), .hwdata(hwdata), .haddr(haddr),
    .hready_resp(rdy2), .hresp(resp2), .hrdata(rdata2)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic ap(input logic s0, input logic s2, input logic wr,
                    input logic [2:0] sz, input logic [31:0] a);
    hsel0  = s0;
    hsel2  = s2;
    hwrite = wr;
    hsize  = sz;
    haddr  = a;
    htrans = 2'b10;
  endtask

  task automatic idle_bus();
    hsel0  = 1'b0;
    hsel2  = 1'b0;
    htrans = 2'b00;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got=%h exp=%h", tag, obs, exp);
    end
    $display("check %s: got=%h exp=%h", tag, obs, exp);
  endtask

  initial begin
    hresetn = 1'b0;
    hsel0 = 1'b0; hsel2 = 1'b0; hwrite = 1'b0; hsize = 3'd0;
    hburst = 3'b001; htrans = 2'b00; hwdata = 32'd0; haddr = 32'd0;
    repeat (2) step();
    chk("rst_rdy0", rdy0, 1);
    chk("rst_resp0", resp0, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdy2", rdy2, 1);
    hresetn = 1'b1;
    step();

    // word write then back-to-back read of the same word
    ap(1, 0, 1, 3'd2, 32'h10); step();
    chk("w10_rdy", rdy0, 1);
    chk("w10_resp", resp0, 0);
    hwdata = 32'hDEADBEEF; ap(1, 0, 0, 3'd2, 32'h10); step();
    chk("r10_data", rdata0, 32'hDEADBEEF);
    chk("r10_rdy", rdy0, 1);
    chk("r10_resp", resp0, 0);
    idle_bus(); step();
    chk("idle_rdata", rdata0, 0);

    ap(1, 0, 1, 3'd2, 32'h4); step();
    hwdata = 32'h5A5A5A5A; ap(1, 0, 0, 3'd2, 32'h4); step();
    chk("b2b_rdy", rdy0, 1);
    chk("b2b_data", rdata0, 32'h5A5A5A5A);
    idle_bus(); step();

    // byte and halfword merges into an existing word
    ap(1, 0, 1, 3'd2, 32'h20); step();
    hwdata = 32'h11223344; ap(1, 0, 1, 3'd0, 32'h21); step();
    hwdata = 32'h0000AA00; ap(1, 0, 0, 3'd2, 32'h20); step();
    chk("byte_merge", rdata0, 32'h1122AA44);
    ap(1, 0, 1, 3'd1, 32'h22); step();
    hwdata = 32'hBEEF0000; ap(1, 0, 0, 3'd2, 32'h20); step();
    chk("half_merge", rdata0, 32'hBEEFAA44);
    idle_bus(); step();

    // selected IDLE and BUSY give plain OKAY
    hsel0 = 1'b1; htrans = 2'b00; step();
    chk("sel_idle_rdy", rdy0, 1);
    chk("sel_idle_resp", resp0, 0);
    htrans = 2'b01; step();
    chk("sel_busy_rdy", rdy0, 1);
    chk("sel_busy_resp", resp0, 0);
    idle_bus(); step();

    // misaligned and out-of-range reads
    ap(1, 0, 0, 3'd2, 32'h102); step();
    chk("mis_e1_rdy", rdy0, 0);
    chk("mis_e1_resp", resp0, 1);
    idle_bus(); step();
    chk("mis_e2_rdy", rdy0, 1);
    chk("mis_e2_resp", resp0, 1);
    step();
    chk("mis_end_resp", resp0, 0);
    ap(1, 0, 0, 3'd2, 32'h100); step();
    chk("oor_e1_rdy", rdy0, 0);
    chk("oor_e1_resp", resp0, 1);
    idle_bus(); step();
    chk("oor_e2_rdy", rdy0, 1);
    chk("oor_e2_resp", resp0, 1);
    step();
    chk("oor_end_rdy", rdy0, 1);

    // error writes must leave memory alone
    ap(1, 0, 1, 3'd2, 32'h22); step();
    hwdata = 32'hFFFFFFFF; idle_bus(); step(); step();
    ap(1, 0, 1, 3'd3, 32'h20); step();
    chk("sz3_resp", resp0, 1);
    idle_bus(); step(); step();
    ap(1, 0, 0, 3'd2, 32'h20); step();
    chk("err_nowrite", rdata0, 32'hBEEFAA44);
    idle_bus(); step();

    // two wait states on a read of untouched memory
    ap(0, 1, 0, 3'd2, 32'h0); step();
    chk("ws_w1_rdy", rdy2, 0);
    chk("ws_w1_resp", resp2, 0);
    idle_bus(); step();
    chk("ws_w2_rdy", rdy2, 0);
    step();
    chk("ws_data_rdy", rdy2, 1);
    chk("ws_data", rdata2, 0);
    step();

    ap(0, 1, 1, 3'd2, 32'h8); step();
    hwdata = 32'h12345678; idle_bus(); step(); step();
    chk("ws_wdata_rdy", rdy2, 1);
    step();
    ap(0, 1, 0, 3'd2, 32'h8); step();
    idle_bus(); step(); step();
    chk("ws_rd8", rdata2, 32'h12345678);
    step();

    // reset pulse during the wait of a write
    ap(0, 1, 1, 3'd2, 32'hC); step();
    hwdata = 32'hCAFEF00D; idle_bus();
    chk("pre_rst_rdy2", rdy2, 0);
    #1 hresetn = 1'b0;
    #1;
    chk("in_rst_rdy2", rdy2, 1);
    chk("in_rst_resp2", resp2, 0);
    #1 hresetn = 1'b1;
    step();
    ap(0, 1, 0, 3'd2, 32'hC); step();
    chk("post_rst_wait", rdy2, 0);
    idle_bus(); step(); step();
    chk("post_rst_rdy", rdy2, 1);
    chk("post_rst_rdC", rdata2, 0);
    step();
    ap(0, 1, 0, 3'd2, 32'h8); step();
    idle_bus(); step(); step();
    chk("post_rst_rd8", rdata2, 0);
    step();
    ap(1, 0, 0, 3'd2, 32'h10); step();
    chk("post_rst_rd10", rdata0, 0);
    idle_bus(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
